// File: rtl/ide_pio_sequencer_if.sv
// ----------------------------------------------------------------------------
// ide_pio_sequencer_if : 68000 bus request side and IDE strobe side of the
//                        ATA PIO sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ide_pio_sequencer_if;
    logic        AS_n;
    logic        UDS_n;
    logic        LDS_n;
    logic        RW;
    logic [13:12] ADDR;
    logic        ide_access;
    logic        ide_enabled;
    logic        IORDY;
    logic        cfg_we;
    logic [1:0]  cfg_mode;
    logic        IOR_n;
    logic        IOW_n;
    logic        IDECS1_n;
    logic        IDECS2_n;
    logic        IDEBUF_OE;
    logic        DTACK;
    logic        busy;
    logic        timeout;

    modport master (
        output AS_n, UDS_n, LDS_n, RW, ADDR, ide_access, ide_enabled, IORDY, cfg_we, cfg_mode,
        input  IOR_n, IOW_n, IDECS1_n, IDECS2_n, IDEBUF_OE, DTACK, busy, timeout
    );

    modport slave (
        input  AS_n, UDS_n, LDS_n, RW, ADDR, ide_access, ide_enabled, IORDY, cfg_we, cfg_mode,
        output IOR_n, IOW_n, IDECS1_n, IDECS2_n, IDEBUF_OE, DTACK, busy, timeout
    );
endinterface

`default_nettype wire

// File: rtl/ide_pio_sequencer.sv
// ----------------------------------------------------------------------------
// ide_pio_sequencer : times ATA PIO setup/strobe/hold/recovery from the PIO
//                     mode; IDE_IORDY_TIMEOUT_EN adds an IORDY wait limit.
//                     Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ide_pio_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic          CLK,
    input  wire logic          RESET_n,
    ide_pio_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACTIVE  = 3'd2,
        HOLD    = 3'd3,
        ACK     = 3'd4,
        RECOVER = 3'd5
    } state_t;

    state_t     state_q;
    logic [1:0] mode_q;
    logic [1:0] cnt_q;
    logic [1:0] a_q, h_q, r_q;
    logic       rw_q;
    logic       ior_n_q, iow_n_q, cs1_n_q, cs2_n_q, oe_n_q, dtack_q, busy_q;

    logic [1:0] s_d, a_d, h_d, r_d;
    logic       w_start, w_cnt_done, w_go_recover, w_iordy_ok, w_to_hit;

    always_comb begin
        case (mode_q)
            2'd0:    {s_d, a_d, h_d, r_d} = {2'd2, 2'd3, 2'd1, 2'd2};
            2'd1:    {s_d, a_d, h_d, r_d} = {2'd1, 2'd2, 2'd1, 2'd2};
            2'd2:    {s_d, a_d, h_d, r_d} = {2'd1, 2'd2, 2'd1, 2'd1};
            default: {s_d, a_d, h_d, r_d} = {2'd1, 2'd1, 2'd0, 2'd1};
        endcase
    end

    // Writes wait for a data strobe so the bus data is valid before IOW_n falls.
    assign w_start      = !bus.AS_n && bus.ide_access && bus.ide_enabled &&
                          (bus.RW || !bus.UDS_n || !bus.LDS_n);
    assign w_cnt_done   = (cnt_q <= 2'd1);
    assign w_go_recover = bus.AS_n && (state_q inside {SETUP, ACTIVE, HOLD, ACK});

`ifdef IDE_IORDY_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q;
    logic              timeout_q;
    assign w_to_hit    = (wait_q == WAIT_W'(TIMEOUT_CYCLES));
    assign bus.timeout = timeout_q;
`else
    assign w_to_hit    = 1'b0;
    assign bus.timeout = 1'b0;
`endif
    assign w_iordy_ok = bus.IORDY || w_to_hit;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            cnt_q   <= 2'd0;
            a_q     <= 2'd0;
            h_q     <= 2'd0;
            r_q     <= 2'd0;
            rw_q    <= 1'b0;
            ior_n_q <= 1'b1;
            iow_n_q <= 1'b1;
            cs1_n_q <= 1'b1;
            cs2_n_q <= 1'b1;
            oe_n_q  <= 1'b1;
            dtack_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef IDE_IORDY_TIMEOUT_EN
            wait_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            if (bus.cfg_we) begin
                mode_q <= bus.cfg_mode;
`ifdef IDE_IORDY_TIMEOUT_EN
                timeout_q <= 1'b0;
`endif
            end
            // AS_n high ends ACK normally and aborts any earlier phase.
            if (w_go_recover) begin
                state_q <= RECOVER;
                cnt_q   <= r_q;
                ior_n_q <= 1'b1;
                iow_n_q <= 1'b1;
                cs1_n_q <= 1'b1;
                cs2_n_q <= 1'b1;
                oe_n_q  <= 1'b1;
                dtack_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (w_start) begin
                        state_q <= SETUP;
                        rw_q    <= bus.RW;
                        cs1_n_q <= !bus.ADDR[12];
                        cs2_n_q <= !bus.ADDR[13];
                        oe_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= s_d;
                        a_q     <= a_d;
                        h_q     <= h_d;
                        r_q     <= r_d;
                    end
                    SETUP: if (w_cnt_done) begin
                        state_q <= ACTIVE;
                        cnt_q   <= a_q;
                        ior_n_q <= !rw_q;
                        iow_n_q <= rw_q;
`ifdef IDE_IORDY_TIMEOUT_EN
                        wait_q  <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                    ACTIVE: if (!w_cnt_done) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else if (w_iordy_ok) begin
`ifdef IDE_IORDY_TIMEOUT_EN
                        if (!bus.IORDY) timeout_q <= 1'b1;
`endif
                        // Reads keep IOR_n low through ACK so data stays driven.
                        if (rw_q) begin
                            state_q <= ACK;
                            dtack_q <= 1'b1;
                        end else begin
                            iow_n_q <= 1'b1;
                            if (h_q == 2'd0) begin
                                state_q <= ACK;
                                dtack_q <= 1'b1;
                            end else begin
                                state_q <= HOLD;
                                cnt_q   <= h_q;
                            end
                        end
                    end
`ifdef IDE_IORDY_TIMEOUT_EN
                    else begin
                        wait_q <= wait_q + 1'b1;
                    end
`endif
                    HOLD: if (w_cnt_done) begin
                        state_q <= ACK;
                        dtack_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                    ACK: ;
                    RECOVER: if (w_cnt_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.IOR_n     = ior_n_q;
    assign bus.IOW_n     = iow_n_q;
    assign bus.IDECS1_n  = cs1_n_q;
    assign bus.IDECS2_n  = cs2_n_q;
    assign bus.IDEBUF_OE = oe_n_q;
    assign bus.DTACK     = dtack_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: doc/ide_pio_sequencer.md
# ide_pio_sequencer

Cycle sequencer for the IDE port's ATA PIO register and data accesses. It replaces the fixed one-clock IOR_n/IOW_n strobing with a state machine that times address setup, strobe width, write hold and recovery from a host-selected PIO mode. It waits on IORDY and returns DTACK to the 68000 bus. It sits between the Zorro/68000 bus decode (ide_access) and the IDE buffers and connector.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: IORDY wait limit in CLK cycles. Only used with IDE_IORDY_TIMEOUT_EN.

Ports:
- CLK  in  1  bus clock, about 7.09 MHz; all state changes on its rising edge.
- RESET_n  in  1  reset, asynchronous and active-low.
- AS_n  in  1  68000 address strobe.
- UDS_n, LDS_n  in  1 each  data strobes; ds = !UDS_n || !LDS_n.
- RW  in  1  1 = read, 0 = write.
- ADDR  in  [13:12]  CS select: bit 12 selects CS1, bit 13 selects CS2.
- ide_access  in  1  decoded IDE register-space access.
- ide_enabled  in  1  IDE port autoconfigured and active.
- IORDY  in  1  drive ready, synchronised externally.
- cfg_we  in  1  one-cycle pulse that loads cfg_mode.
- cfg_mode  in  [1:0]  PIO mode, 0 to 3.
- IOR_n, IOW_n  out  1  drive strobes.
- IDECS1_n, IDECS2_n  out  1  drive chip selects.
- IDEBUF_OE  out  1  data buffer enable, active-low.
- DTACK  out  1  bus acknowledge, active-high.
- busy  out  1  asserted in any state other than IDLE.
- timeout  out  1  sticky flag, set by an IORDY timeout.

## Operation
- Reset values: IOR_n=1, IOW_n=1, IDECS1_n=1, IDECS2_n=1, IDEBUF_OE=1, DTACK=0, busy=0, timeout=0, mode=0. The sequencer is in IDLE.
- Mode register: updated on cfg_we in any state. Counts (S, A, H, R) are latched on leaving IDLE, so a write during a cycle takes effect from the next cycle.
- Count table in CLK cycles (S, A, H, R):
  - mode 0: 2, 3, 1, 2
  - mode 1: 1, 2, 1, 2
  - mode 2: 1, 2, 1, 1
  - mode 3: 1, 1, 0, 1
- Start condition: !AS_n && ide_access && ide_enabled. Reads start when this holds. Writes additionally require ds, so data is valid before the strobe.
- States:
  - IDLE: wait for the start condition. On start, latch RW and ADDR[13:12], drive CS from the latched address, then go to SETUP.
  - SETUP: hold for S cycles, then go to ACTIVE. IDEBUF_OE is asserted from SETUP onward.
  - ACTIVE: IOR_n=!RW and IOW_n=RW. Hold for A cycles. After that, stay while IORDY=0.
    - Read: go to ACK with IOR_n kept low, so read data stays valid until the bus cycle ends.
    - Write: go to HOLD with IOW_n high. If H=0, go directly to ACK.
  - HOLD: IOW_n high, CS and buffer kept. Hold for H cycles, then go to ACK.
  - ACK: DTACK=1. Stay until AS_n=1, then go to RECOVER.
  - RECOVER: strobes, CS, IDEBUF_OE and DTACK all inactive. Hold for R cycles, then go to IDLE. A start request pending during RECOVER is taken on the first IDLE cycle.
- AS_n rising in SETUP, ACTIVE or HOLD: abort to RECOVER on the next edge. No DTACK is issued and timeout is unchanged.
- ide_enabled=0 has no effect on a cycle already in progress.
- RESET_n low in any state: all outputs go to their reset values immediately (asynchronously) and the state returns to IDLE.

## Timing
- Read, mode 3, IORDY high, start sampled at edge 0:
  - CS low after edge 0.
  - IOR_n low after edge 1.
  - DTACK high after edge 2.
- Write latency from start to DTACK: S + A + H cycles, plus any IORDY extension.
- All outputs are registered. No combinational path from inputs to outputs.
- Counters count down from the latched value. A count of 0 exits the state on the same edge it is entered; only H may be 0.

## Configuration
- IDE_IORDY_TIMEOUT_EN defined:
  - A wait counter runs while ACTIVE is extended by IORDY=0.
  - When it reaches TIMEOUT_CYCLES, set timeout, release the strobe and proceed to HOLD/ACK as normal, so the bus cannot hang.
  - timeout clears only on reset or on cfg_we.
- IDE_IORDY_TIMEOUT_EN undefined: ACTIVE waits indefinitely on IORDY, and timeout is tied to 0.

## Test plan
- Reset mid-ACTIVE, then release: all outputs at reset values immediately; next access runs in mode 0.
- Mode 0 read, ADDR[12]=1, IORDY=1: IDECS1_n low for 2 + 3 cycles before DTACK. IOR_n low for 3 cycles plus the ACK period. DTACK drops on the edge after AS_n rises, followed by 2 recovery cycles.
- Mode 3 write, ADDR[13]=1, ds one cycle after AS_n: no start until ds. IOW_n low for exactly 1 cycle. H=0, so DTACK follows on the next edge.
- IORDY held low 5 cycles in ACTIVE (mode 2): strobe width is 2 + 5 cycles; DTACK is delayed by the same 5 cycles.
- cfg_we with mode 3 during a mode 0 cycle: current cycle keeps mode 0 counts; next cycle uses mode 3 counts.
- With IDE_IORDY_TIMEOUT_EN and TIMEOUT_CYCLES=8, IORDY stuck low: timeout=1, DTACK asserted, busy returns to 0 after recovery. Without the macro, busy stays 1 and DTACK stays 0.
